// File: rtl/rf_scoreboard_if.sv
// Purpose: decode-side issue/source bundle plus writeback/squash events for rf_scoreboard.
// Latency: wires only; stall/fwd are combinational and busy_vec is registered inside the scoreboard.
// Backpressure: stall refuses the issue presented this cycle; wb/squash events are never refused.
interface rf_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NSRC = 2,
    parameter int CW   = 3
);
    logic                 arm;
    logic                 issue_valid;
    logic                 issue_we;
    logic [AW-1:0]        issue_rd;
    logic                 issue_fixed;
    logic [CW-1:0]        issue_lat;
    logic [NSRC-1:0]      src_en;
    logic [NSRC*AW-1:0]   src_rs;
    logic                 wb_valid;
    logic [AW-1:0]        wb_rd;
    logic                 squash_valid;
    logic [AW-1:0]        squash_rd;
    logic                 stall;
    logic [NSRC-1:0]      fwd;
    logic [NREG-1:0]      busy_vec;

    // Pipeline / decode side drives the requests and watches the verdicts.
    modport master (
        output arm, issue_valid, issue_we, issue_rd, issue_fixed, issue_lat,
               src_en, src_rs, wb_valid, wb_rd, squash_valid, squash_rd,
        input  stall, fwd, busy_vec
    );

    // Scoreboard side.
    modport slave (
        input  arm, issue_valid, issue_we, issue_rd, issue_fixed, issue_lat,
               src_en, src_rs, wb_valid, wb_rd, squash_valid, squash_rd,
        output stall, fwd, busy_vec
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Purpose: per-register pending-write scoreboard producing decode stall and per-source forward flags.
// Latency: stall/fwd combinational from state and inputs; state (busy_vec) updates on the next edge.
// Backpressure: a stalled issue leaves state untouched so the same instruction re-evaluates next cycle.
module rf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NSRC = 2,
    parameter int CW   = 3
) (
    input  logic           clk,
    input  logic           rst,
    rf_scoreboard_if.slave sb
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] isVar;
    logic [CW-1:0]   cnt [NREG];

    logic [NSRC-1:0] srcHaz;
    logic [NSRC-1:0] fwdVec;
    logic            wawHaz;
    logic            stallInt;
    logic            accept;
    logic [NREG-1:0] rdHit;
    logic [NREG-1:0] clrHit;

    // r15 is the PC in ARM mode, x0 is hardwired in RISC-V mode; indices past NREG do not exist.
    function automatic logic isTracked(input logic [AW-1:0] idx, input logic armMode);
        isTracked = 1'b1;
        if (32'(idx) >= 32'(NREG))
            isTracked = 1'b0;
        if (armMode && (32'(idx) == 32'd15))
            isTracked = 1'b0;
        if (!armMode && (32'(idx) == 32'd0))
            isTracked = 1'b0;
    endfunction

    // Per-source hazard and bypass flags; fixed writers become forwardable once their count hits zero.
    always_comb begin : srcCheck
        logic [AW-1:0] rs;
        logic          eBusy;
        logic          eVar;
        logic          eZero;
        srcHaz = '0;
        fwdVec = '0;
        for (int i = 0; i < NSRC; i++) begin
            rs    = sb.src_rs[i*AW +: AW];
            eBusy = 1'b0;
            eVar  = 1'b0;
            eZero = 1'b1;
            for (int r = 0; r < NREG; r++) begin
                if (rs == AW'(r)) begin
                    eBusy = busy[r];
                    eVar  = isVar[r];
                    eZero = (cnt[r] == '0);
                end
            end
            if (sb.src_en[i] && isTracked(rs, sb.arm) && eBusy) begin
                srcHaz[i] = eVar || !eZero;
                fwdVec[i] = !eVar && eZero;
            end
        end
    end

    // Destination decode: WAW against a variable-latency writer, plus one-hot set/clear masks.
    always_comb begin : dstCheck
        logic rdTracked;
        logic wbTracked;
        logic sqTracked;
        rdTracked = isTracked(sb.issue_rd, sb.arm);
        wbTracked = isTracked(sb.wb_rd, sb.arm);
        sqTracked = isTracked(sb.squash_rd, sb.arm);
        wawHaz    = 1'b0;
        rdHit     = '0;
        clrHit    = '0;
        for (int r = 0; r < NREG; r++) begin
            if (sb.issue_rd == AW'(r)) begin
                rdHit[r] = rdTracked;
                if (sb.issue_we && rdTracked && busy[r] && isVar[r])
                    wawHaz = 1'b1;
            end
            if (sb.wb_valid && wbTracked && (sb.wb_rd == AW'(r)))
                clrHit[r] = 1'b1;
            if (sb.squash_valid && sqTracked && (sb.squash_rd == AW'(r)))
                clrHit[r] = 1'b1;
        end
        stallInt = rst && sb.issue_valid && ((|srcHaz) || wawHaz);
        accept   = rst && sb.issue_valid && !stallInt && sb.issue_we;
    end

    assign sb.stall    = stallInt;
    assign sb.fwd      = fwdVec;
    assign sb.busy_vec = busy;

    // State update per register: new issue beats wb/squash, which beats the latency countdown.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy  <= '0;
            isVar <= '0;
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (accept && rdHit[r]) begin
                    busy[r]  <= 1'b1;
                    isVar[r] <= !sb.issue_fixed;
                    cnt[r]   <= sb.issue_fixed ? sb.issue_lat : '0;
                end else if (clrHit[r]) begin
                    busy[r]  <= 1'b0;
                    isVar[r] <= 1'b0;
                    cnt[r]   <= '0;
                end else if (busy[r] && !isVar[r] && (cnt[r] != '0)) begin
                    cnt[r]   <= cnt[r] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Purpose: directed checks of rf_scoreboard in the default build and an NSRC=3/NREG=16 build.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1ns later or after the next edge.
// Backpressure: stall is checked directly; no handshake waits, every phase is a fixed cycle count.
module tb_rf_scoreboard;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFails;

    rf_scoreboard_if #(.NREG(32), .AW(5), .NSRC(2), .CW(3)) ifA ();
    rf_scoreboard_if #(.NREG(16), .AW(4), .NSRC(3), .CW(3)) ifB ();

    rf_scoreboard #(.NREG(32), .AW(5), .NSRC(2), .CW(3)) dutA (
        .clk (clk),
        .rst (rst),
        .sb  (ifA)
    );

    rf_scoreboard #(.NREG(16), .AW(4), .NSRC(3), .CW(3)) dutB (
        .clk (clk),
        .rst (rst),
        .sb  (ifB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleA();
        ifA.issue_valid  = 1'b0;
        ifA.issue_we     = 1'b0;
        ifA.issue_rd     = '0;
        ifA.issue_fixed  = 1'b1;
        ifA.issue_lat    = '0;
        ifA.src_en       = '0;
        ifA.src_rs       = '0;
        ifA.wb_valid     = 1'b0;
        ifA.wb_rd        = '0;
        ifA.squash_valid = 1'b0;
        ifA.squash_rd    = '0;
    endtask

    task automatic idleB();
        ifB.issue_valid  = 1'b0;
        ifB.issue_we     = 1'b0;
        ifB.issue_rd     = '0;
        ifB.issue_fixed  = 1'b1;
        ifB.issue_lat    = '0;
        ifB.src_en       = '0;
        ifB.src_rs       = '0;
        ifB.wb_valid     = 1'b0;
        ifB.wb_rd        = '0;
        ifB.squash_valid = 1'b0;
        ifB.squash_rd    = '0;
    endtask

    task automatic issueA(input logic [4:0] rd, input logic fixed, input logic [2:0] lat);
        ifA.issue_valid = 1'b1;
        ifA.issue_we    = 1'b1;
        ifA.issue_rd    = rd;
        ifA.issue_fixed = fixed;
        ifA.issue_lat   = lat;
    endtask

    task automatic readA(input logic [4:0] rs);
        ifA.issue_valid = 1'b1;
        ifA.src_en      = 2'b01;
        ifA.src_rs      = {5'd0, rs};
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        rst     = 1'b0;
        idleA();
        idleB();
        ifA.arm = 1'b0;
        ifB.arm = 1'b0;

        // Reset held with an issue pending: nothing may be accepted.
        issueA(5'd5, 1'b1, 3'd0);
        #1;
        check("rst_stall", 32'(ifA.stall), 32'd0);
        step();
        step();
        check("rst_busy", ifA.busy_vec, 32'h0);
        check("rst_stall_held", 32'(ifA.stall), 32'd0);
        check("rst_busy_b", 32'(ifB.busy_vec), 32'h0);
        rst = 1'b1;
        #1;
        check("rel_stall", 32'(ifA.stall), 32'd0);
        step();
        check("rel_busy5", ifA.busy_vec, 32'h20);
        idleA();
        ifA.wb_valid = 1'b1;
        ifA.wb_rd    = 5'd5;
        step();
        idleA();
        check("wb5_clear", ifA.busy_vec, 32'h0);

        // Load-use: lat=1 gives exactly one stall cycle then bypass.
        issueA(5'd3, 1'b1, 3'd1);
        step();
        idleA();
        readA(5'd3);
        #1;
        check("lu_stall", 32'(ifA.stall), 32'd1);
        check("lu_fwd_early", 32'(ifA.fwd), 32'd0);
        step();
        check("lu_stall_done", 32'(ifA.stall), 32'd0);
        check("lu_fwd", 32'(ifA.fwd), 32'd1);
        ifA.issue_valid = 1'b0;
        ifA.wb_valid    = 1'b1;
        ifA.wb_rd       = 5'd3;
        step();
        ifA.wb_valid = 1'b0;
        #1;
        check("lu_wb_busy", ifA.busy_vec, 32'h0);
        check("lu_wb_fwd", 32'(ifA.fwd), 32'd0);

        // Variable latency: stall until the cycle after wb, then register-file read.
        idleA();
        issueA(5'd7, 1'b0, 3'd0);
        step();
        idleA();
        readA(5'd7);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                ifA.wb_valid = 1'b1;
                ifA.wb_rd    = 5'd7;
            end
            #1;
            check($sformatf("var_stall%0d", i), 32'(ifA.stall), 32'd1);
            step();
        end
        ifA.wb_valid = 1'b0;
        #1;
        check("var_release_stall", 32'(ifA.stall), 32'd0);
        check("var_release_fwd", 32'(ifA.fwd), 32'd0);
        check("var_release_busy", ifA.busy_vec, 32'h0);

        // WAW against a pending variable writer.
        idleA();
        issueA(5'd7, 1'b0, 3'd0);
        step();
        issueA(5'd7, 1'b1, 3'd0);
        #1;
        check("waw_stall", 32'(ifA.stall), 32'd1);
        step();
        check("waw_busy", ifA.busy_vec, 32'h80);
        check("waw_still", 32'(ifA.stall), 32'd1);
        idleA();
        ifA.squash_valid = 1'b1;
        ifA.squash_rd    = 5'd7;
        step();
        idleA();
        check("waw_squash", ifA.busy_vec, 32'h0);

        // Untracked registers in each ISA mode.
        issueA(5'd0, 1'b1, 3'd3);
        step();
        check("utr_x0", ifA.busy_vec, 32'h0);
        issueA(5'd15, 1'b1, 3'd3);
        step();
        check("utr_x15_rv", ifA.busy_vec, 32'h8000);
        ifA.arm = 1'b1;
        issueA(5'd15, 1'b1, 3'd2);
        readA(5'd15);
        #1;
        check("arm_r15_stall", 32'(ifA.stall), 32'd0);
        check("arm_r15_fwd", 32'(ifA.fwd), 32'd0);
        step();
        check("arm_r15_issue", ifA.busy_vec, 32'h8000);
        idleA();
        issueA(5'd0, 1'b1, 3'd0);
        step();
        check("arm_r0_tracked", ifA.busy_vec, 32'h8001);
        idleA();
        ifA.squash_valid = 1'b1;
        ifA.squash_rd    = 5'd15;
        ifA.wb_valid     = 1'b1;
        ifA.wb_rd        = 5'd0;
        step();
        idleA();
        check("arm_r15_squash_ignored", ifA.busy_vec, 32'h8000);
        ifA.arm      = 1'b0;
        ifA.wb_valid = 1'b1;
        ifA.wb_rd    = 5'd15;
        step();
        idleA();
        check("rv_x15_wb", ifA.busy_vec, 32'h0);

        // Simultaneous events.
        issueA(5'd9, 1'b0, 3'd0);
        step();
        issueA(5'd10, 1'b0, 3'd0);
        step();
        issueA(5'd4, 1'b1, 3'd5);
        step();
        check("sim_setup", ifA.busy_vec, 32'h610);
        issueA(5'd4, 1'b1, 3'd2);
        ifA.wb_valid = 1'b1;
        ifA.wb_rd    = 5'd4;
        #1;
        check("sim_accept_stall", 32'(ifA.stall), 32'd0);
        step();
        idleA();
        check("sim_accept_busy", ifA.busy_vec, 32'h610);
        readA(5'd4);
        #1;
        check("sim_cnt2_a", 32'(ifA.stall), 32'd1);
        step();
        check("sim_cnt2_b", 32'(ifA.stall), 32'd1);
        step();
        check("sim_cnt2_done", 32'(ifA.stall), 32'd0);
        check("sim_cnt2_fwd", 32'(ifA.fwd), 32'd1);
        idleA();
        ifA.squash_valid = 1'b1;
        ifA.squash_rd    = 5'd9;
        ifA.wb_valid     = 1'b1;
        ifA.wb_rd        = 5'd10;
        step();
        idleA();
        check("sim_sq_wb", ifA.busy_vec, 32'h10);
        ifA.wb_valid = 1'b1;
        ifA.wb_rd    = 5'd4;
        step();
        idleA();
        check("sim_final", ifA.busy_vec, 32'h0);

        // Three-source, 16-register build: only source 2 collides.
        ifB.issue_valid = 1'b1;
        ifB.issue_we    = 1'b1;
        ifB.issue_rd    = 4'd6;
        ifB.issue_fixed = 1'b1;
        ifB.issue_lat   = 3'd2;
        step();
        idleB();
        ifB.issue_valid = 1'b1;
        ifB.src_en      = 3'b111;
        ifB.src_rs      = {4'd6, 4'd2, 4'd1};
        #1;
        check("b_busy", 32'(ifB.busy_vec), 32'h40);
        check("b_stall0", 32'(ifB.stall), 32'd1);
        step();
        check("b_stall1", 32'(ifB.stall), 32'd1);
        step();
        check("b_stall_done", 32'(ifB.stall), 32'd0);
        check("b_fwd", 32'(ifB.fwd), 32'h4);
        idleB();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
